// File: rtl/main_fsm.sv
// Multicycle RV32I-subset main controller: sequences fetch/decode/execute/memory/writeback
// and drives every datapath enable, mux select and the ALUOp to the ALU decoder.
module main_fsm #(
   parameter int MEM_TIMEOUT = 0,
   parameter int CNT_W       = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       zero,
   input  logic       lt,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic [1:0] ALUOp,
   output logic       illegal,
   output logic       mem_err,
   output logic       retire
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   state_t           state, nxt;
   logic [CNT_W-1:0] tcnt;
   logic             waiting, tmo, taken;
   logic [1:0]       imm_op;

   // Only the three states that talk to memory can stall on mem_ready.
   assign waiting = ((state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE))
                    && !mem_ready;
   assign tmo     = (MEM_TIMEOUT != 0) && waiting && (tcnt == CNT_W'(MEM_TIMEOUT));

   always_comb begin
      case (op)
         OP_STORE:  imm_op = 2'b01;
         OP_BRANCH: imm_op = 2'b10;
         OP_JAL:    imm_op = 2'b11;
         default:   imm_op = 2'b00;
      endcase
   end

   always_comb begin
      case (funct3)
         3'b000:  taken = zero;
         3'b001:  taken = ~zero;
         3'b100:  taken = lt;
         default: taken = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_FETCH;
         tcnt  <= '0;
      end else begin
         state <= nxt;
         // An aborted FETCH stays in FETCH, so the abort must clear the count too.
         if ((nxt != state) || tmo) tcnt <= '0;
         else if (waiting)          tcnt <= tcnt + 1'b1;
         else                       tcnt <= '0;
      end
   end

   always_comb begin
      nxt       = S_FETCH;
      PCWrite   = 1'b0;
      AdrSrc    = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ImmSrc    = 2'b00;
      ALUOp     = 2'b00;
      illegal   = 1'b0;
      mem_err   = 1'b0;
      retire    = 1'b0;
      case (state)
         S_FETCH: begin
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            IRWrite   = mem_ready;
            PCWrite   = mem_ready;
            if (mem_ready) nxt = S_DECODE;
            else           mem_err = tmo;
         end
         S_DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            ImmSrc  = imm_op;
            case (op)
               OP_LOAD, OP_STORE: nxt = S_MEMADR;
               OP_RTYPE:          nxt = S_EXECUTER;
               OP_ITYPE:          nxt = S_EXECUTEI;
               OP_BRANCH:         nxt = S_BRANCH;
               OP_JAL:            nxt = S_JAL;
               default: begin
                  illegal = 1'b1;
                  retire  = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            ImmSrc  = imm_op;
            nxt     = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            AdrSrc = 1'b1;
            if (mem_ready) nxt = S_MEMWB;
            else if (tmo)  mem_err = 1'b1;
            else           nxt = S_MEMREAD;
         end
         S_MEMWB: begin
            ResultSrc = 2'b01;
            RegWrite  = 1'b1;
            retire    = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
            if (mem_ready) retire = 1'b1;
            else if (tmo)  mem_err = 1'b1;
            else           nxt = S_MEMWRITE;
         end
         S_EXECUTER: begin
            ALUSrcA = 2'b10;
            ALUOp   = 2'b10;
            nxt     = S_ALUWB;
         end
         S_EXECUTEI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            ALUOp   = 2'b10;
            nxt     = S_ALUWB;
         end
         S_ALUWB: begin
            RegWrite = 1'b1;
            retire   = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA = 2'b10;
            ALUOp   = 2'b01;
            ImmSrc  = 2'b10;
            PCWrite = taken;
            retire  = 1'b1;
         end
         S_JAL: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
            ImmSrc  = 2'b11;
            PCWrite = 1'b1;
            nxt     = S_ALUWB;
         end
         default: nxt = S_FETCH;
      endcase
   end

endmodule

// File: tb/tb_main_fsm.sv
// Directed bench for main_fsm: every cycle's full output vector is compared against
// a hand-written expectation for the state the instruction should be in.
module tb_main_fsm;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       zero, lt, mem_ready;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUOp;
   logic       illegal, mem_err, retire;

   int checks = 0;
   int errors = 0;

   main_fsm #(.MEM_TIMEOUT(3), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .zero(zero), .lt(lt),
      .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUOp(ALUOp), .illegal(illegal),
      .mem_err(mem_err), .retire(retire)
   );

   always #5 clk = ~clk;

   // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUOp,illegal,mem_err,retire}
   function automatic logic [17:0] o(input logic pcw, adr, mw, irw, rw, input logic [1:0] rs, sa, sb,
                                     imm, aop, input logic ill, merr, ret);
      return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, aop, ill, merr, ret};
   endfunction

   function automatic logic [17:0] e_f(input logic mr, merr);
      return o(mr, 0, 0, mr, 0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd0, 0, merr, 0);
   endfunction
   function automatic logic [17:0] e_d(input logic [1:0] imm, input logic ill);
      return o(0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, imm, 2'd0, ill, 0, ill);
   endfunction
   function automatic logic [17:0] e_ma(input logic [1:0] imm);
      return o(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, imm, 2'd0, 0, 0, 0);
   endfunction
   function automatic logic [17:0] e_mr(input logic merr);
      return o(0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0, merr, 0);
   endfunction
   function automatic logic [17:0] e_mwr(input logic ret, merr);
      return o(0, 1, 1, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0, merr, ret);
   endfunction
   function automatic logic [17:0] e_mwb();
      return o(0, 0, 0, 0, 1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 1);
   endfunction
   function automatic logic [17:0] e_ex(input logic [1:0] sb);
      return o(0, 0, 0, 0, 0, 2'd0, 2'd2, sb, 2'd0, 2'd2, 0, 0, 0);
   endfunction
   function automatic logic [17:0] e_awb();
      return o(0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 1);
   endfunction
   function automatic logic [17:0] e_br(input logic t);
      return o(t, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 2'd2, 2'd1, 0, 0, 1);
   endfunction
   function automatic logic [17:0] e_jal();
      return o(1, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 0, 0, 0);
   endfunction

   task automatic ck(input string tag, input logic [17:0] exp);
      logic [17:0] got;
      got = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
             ImmSrc, ALUOp, illegal, mem_err, retire};
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%05h exp=%05h", tag, got, exp);
      end
   endtask

   // Inputs are already applied; settle, compare, then advance one clock.
   task automatic cyc(input string tag, input logic [17:0] exp);
      #1;
      ck(tag, exp);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; op = 7'd0; funct3 = 3'd0; zero = 1'b0; lt = 1'b0; mem_ready = 1'b0;
      #1;
      ck("reset", e_f(0, 0));
      #11 rst_n = 1'b1;
      @(posedge clk); #1;

      // lw then sw, memory always ready
      mem_ready = 1'b1; op = 7'b0000011;
      cyc("lw_f", e_f(1, 0)); cyc("lw_d", e_d(2'd0, 0)); cyc("lw_ma", e_ma(2'd0));
      cyc("lw_mr", e_mr(0));  cyc("lw_mwb", e_mwb());
      op = 7'b0100011;
      cyc("sw_f", e_f(1, 0)); cyc("sw_d", e_d(2'd1, 0)); cyc("sw_ma", e_ma(2'd1));
      cyc("sw_mwr", e_mwr(1, 0));

      // R-type and I-type ALU ops
      op = 7'b0110011;
      cyc("r_f", e_f(1, 0)); cyc("r_d", e_d(2'd0, 0)); cyc("r_ex", e_ex(2'd0)); cyc("r_wb", e_awb());
      op = 7'b0010011;
      cyc("i_f", e_f(1, 0)); cyc("i_d", e_d(2'd0, 0)); cyc("i_ex", e_ex(2'd1)); cyc("i_wb", e_awb());

      // branches: beq taken/not, bne, blt, unsupported funct3
      op = 7'b1100011;
      funct3 = 3'b000; zero = 1'b1; lt = 1'b0;
      cyc("beq1_f", e_f(1, 0)); cyc("beq1_d", e_d(2'd2, 0)); cyc("beq1_br", e_br(1));
      zero = 1'b0;
      cyc("beq0_f", e_f(1, 0)); cyc("beq0_d", e_d(2'd2, 0)); cyc("beq0_br", e_br(0));
      funct3 = 3'b001;
      cyc("bne_f", e_f(1, 0)); cyc("bne_d", e_d(2'd2, 0)); cyc("bne_br", e_br(1));
      funct3 = 3'b100; lt = 1'b1;
      cyc("blt_f", e_f(1, 0)); cyc("blt_d", e_d(2'd2, 0)); cyc("blt_br", e_br(1));
      funct3 = 3'b010; zero = 1'b1;
      cyc("b010_f", e_f(1, 0)); cyc("b010_d", e_d(2'd2, 0)); cyc("b010_br", e_br(0));
      zero = 1'b0; lt = 1'b0; funct3 = 3'b000;

      // jal
      op = 7'b1101111;
      cyc("jal_f", e_f(1, 0)); cyc("jal_d", e_d(2'd3, 0)); cyc("jal_j", e_jal()); cyc("jal_wb", e_awb());

      // store timeout: four stalled cycles then abort without retire
      op = 7'b0100011;
      cyc("swt_f", e_f(1, 0)); cyc("swt_d", e_d(2'd1, 0)); cyc("swt_ma", e_ma(2'd1));
      mem_ready = 1'b0;
      cyc("swt_w0", e_mwr(0, 0)); cyc("swt_w1", e_mwr(0, 0)); cyc("swt_w2", e_mwr(0, 0));
      cyc("swt_abort", e_mwr(0, 1));
      mem_ready = 1'b1;
      cyc("swt_refetch", e_f(1, 0));
      // same store, ready arrives on the cycle the timeout would hit
      cyc("swr_d", e_d(2'd1, 0)); cyc("swr_ma", e_ma(2'd1));
      mem_ready = 1'b0;
      cyc("swr_w0", e_mwr(0, 0)); cyc("swr_w1", e_mwr(0, 0)); cyc("swr_w2", e_mwr(0, 0));
      mem_ready = 1'b1;
      cyc("swr_done", e_mwr(1, 0));

      // fetch timeout, then the counter starts over
      mem_ready = 1'b0;
      cyc("ft_w0", e_f(0, 0)); cyc("ft_w1", e_f(0, 0)); cyc("ft_w2", e_f(0, 0));
      cyc("ft_abort", e_f(0, 1)); cyc("ft_after", e_f(0, 0));

      // unsupported opcode
      mem_ready = 1'b1; op = 7'b1111111;
      cyc("ill_f", e_f(1, 0)); cyc("ill_d", e_d(2'd0, 1)); cyc("ill_back", e_f(1, 0));

      // async reset in the middle of a stalled load
      op = 7'b0000011;
      cyc("rl_d", e_d(2'd0, 0)); cyc("rl_ma", e_ma(2'd0));
      mem_ready = 1'b0;
      cyc("rl_mr", e_mr(0));
      rst_n = 1'b0;
      #1;
      ck("rst_midload", e_f(0, 0));
      @(posedge clk); #2;
      rst_n = 1'b1;
      cyc("rst_w0", e_f(0, 0)); cyc("rst_w1", e_f(0, 0)); cyc("rst_w2", e_f(0, 0));
      cyc("rst_abort", e_f(0, 1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
